// File: rtl/note_scheduler.sv
// note_scheduler: arbitrates eight debounced keys for the shared sine oscillator.
// Picks the highest held key, loads its period into the oscillator on a frame
// boundary, confirms the readback and unmutes the audio path once it matches.

// Per-key front end: 2-flop synchronizer followed by a frame-counted debouncer.
module key_debounce #(
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  input  logic frame_sig,
  output logic deb
);
  // Count of the last frame before a flip, so the flip lands on the Nth frame.
  localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_FRAMES - 1);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic [3:0] cnt_q, cnt_d;
  logic       deb_q, deb_d;

  // Next-state: counter runs on frames only while the synced level disagrees.
  always_comb begin
    sync1_d = key_raw;
    sync2_d = sync1_q;
    cnt_d   = cnt_q;
    deb_d   = deb_q;
    if (sync2_q == deb_q) begin
      cnt_d = '0;
    end else if (frame_sig) begin
      if (cnt_q == DB_LAST) begin
        deb_d = ~deb_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  // Synchronizer, counter and stable state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      deb_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      deb_q   <= deb_d;
    end
  end

  assign deb = deb_q;
endmodule

module note_scheduler #(
  parameter int N_KEYS          = 8,
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int RESET_PERIOD    = 48
) (
  input  logic              BIT_CLK,
  input  logic              RESET,
  input  logic [N_KEYS-1:0] KEYS,
  input  logic              frame_sig,
  input  logic [6:0]        FP_PERIOD,
  output logic [6:0]        FP_PERIOD_IN,
  output logic              en,
  output logic              MUTE,
  output logic [2:0]        ACTIVE_KEY,
  output logic              BUSY
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT_ACK, S_PLAY} state_t;

  logic [N_KEYS-1:0] deb;
  logic              win_vld;
  logic [2:0]        win_idx;

  state_t     state_q, state_d;
  logic       en_q, en_d;
  logic       mute_q, mute_d;
  logic [2:0] key_q, key_d;
  logic [6:0] per_q, per_d;

  // Frame period for each key; all entries keep the phase step at 1 or more.
  function automatic logic [6:0] period_lut(input logic [2:0] k);
    case (k)
      3'd0:    period_lut = 7'd88;
      3'd1:    period_lut = 7'd78;
      3'd2:    period_lut = 7'd70;
      3'd3:    period_lut = 7'd66;
      3'd4:    period_lut = 7'd59;
      3'd5:    period_lut = 7'd52;
      3'd6:    period_lut = 7'd47;
      default: period_lut = 7'd44;
    endcase
  endfunction

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    key_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_deb (
      .clk      (BIT_CLK),
      .rst      (RESET),
      .key_raw  (KEYS[k]),
      .frame_sig(frame_sig),
      .deb      (deb[k])
    );
  end

  // Priority encoder: the highest-index held key wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = 0; k < N_KEYS; k++) begin
      if (deb[k]) begin
        win_vld = 1'b1;
        win_idx = 3'(k);
      end
    end
  end

  // FSM next-state; en is only ever raised from LOAD on a frame.
  always_comb begin
    state_d = state_q;
    en_d    = 1'b0;
    mute_d  = mute_q;
    key_d   = key_q;
    per_d   = per_q;
    case (state_q)
      S_IDLE: begin
        mute_d = 1'b1;
        if (win_vld) begin
          key_d   = win_idx;
          per_d   = period_lut(win_idx);
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (frame_sig) begin
          en_d    = 1'b1;
          state_d = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        // First cycle here carries en; the readback is judged on the next one.
        if (!en_q) begin
          if (FP_PERIOD == per_q) begin
            mute_d  = 1'b0;
            state_d = S_PLAY;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_PLAY: begin
        if (!deb[key_q]) begin
          if (win_vld) begin
            key_d   = win_idx;
            per_d   = period_lut(win_idx);
            state_d = S_LOAD;
          end else begin
            mute_d  = 1'b1;
            state_d = S_IDLE;
          end
        end else if (win_vld && (win_idx > key_q)) begin
          key_d   = win_idx;
          per_d   = period_lut(win_idx);
          state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state and registered outputs; reset truncates an en in flight.
  always_ff @(posedge BIT_CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      en_q    <= 1'b0;
      mute_q  <= 1'b1;
      key_q   <= '0;
      per_q   <= 7'(RESET_PERIOD);
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      mute_q  <= mute_d;
      key_q   <= key_d;
      per_q   <= per_d;
    end
  end

  assign FP_PERIOD_IN = per_q;
  assign en           = en_q;
  assign MUTE         = mute_q;
  assign ACTIVE_KEY   = key_q;
  assign BUSY         = (state_q == S_LOAD) || (state_q == S_WAIT_ACK);
endmodule

// File: doc/note_scheduler.md
# note_scheduler

Arbitrates eight debounced key inputs for the single shared sine-wave oscillator and sequences its period reload. Selects the highest-index held key and looks up its frame period. Issues a one-cycle load strobe aligned to a frame boundary, confirms the oscillator's period readback, and gates the audio path with a mute flag. Sits between the front-panel key inputs and the sine generator, in the BIT_CLK domain.

## Interface
- N_KEYS, 8: number of key requesters (fixed by period table; not to be changed).
- DEBOUNCE_FRAMES, 4: consecutive frames a synchronized key must hold a new level before it is accepted (1..15).
- RESET_PERIOD, 48: period driven on FP_PERIOD_IN out of reset; matches the oscillator's power-up period.
- BIT_CLK  in  1  system clock; all logic on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- KEYS  in  8  raw, asynchronous key levels, 1 = pressed.
- frame_sig  in  1  one-cycle frame strobe, also consumed by the oscillator.
- FP_PERIOD  in  7  oscillator's current period readback.
- FP_PERIOD_IN  out  7  period to load into the oscillator.
- en  out  1  one-cycle load strobe to the oscillator.
- MUTE  out  1  1 = downstream audio forced silent.
- ACTIVE_KEY  out  3  index of the key currently owning the oscillator.
- BUSY  out  1  1 while a reload is in flight (LOAD or WAIT_ACK).

## Operation
- Period table, key 0..7: 88, 78, 70, 66, 59, 52, 47, 44. All entries are ≤ 88, so the oscillator's phase step is ≥ 1.
- Each key passes through a 2-flop synchronizer and a debouncer. The debouncer holds a stable state `deb[k]` (reset 0) and a 4-bit counter.
  - The counter advances only on frame_sig while the synced level differs from `deb[k]`, and clears whenever the levels agree.
  - When the counter reaches DEBOUNCE_FRAMES, `deb[k]` flips and the counter clears.
- Winner = highest k with `deb[k]=1`. There is no winner when all `deb` bits are 0.
- FSM states:
  - IDLE: MUTE=1. If a winner exists, latch it to ACTIVE_KEY, drive FP_PERIOD_IN = table[winner], and go to LOAD.
  - LOAD: wait for frame_sig=1. On that cycle, register en=1 for the next cycle and go to WAIT_ACK.
  - WAIT_ACK: on the cycle after en (en is back to 0), compare FP_PERIOD with FP_PERIOD_IN.
    - Equal: go to PLAY.
    - Not equal: return to LOAD and retry at the next frame.
  - PLAY: MUTE=0.
    - `deb[ACTIVE_KEY]` falls and no other key is held: go to IDLE. MUTE=1 is effective the next cycle.
    - `deb[ACTIVE_KEY]` falls and other keys are held: latch the new winner and go to LOAD.
    - A key with a higher index than ACTIVE_KEY becomes debounced-held: preempt, latch it, and go to LOAD. MUTE stays 0 across a preempt.
    - A newly held lower key: ignored.
- Key changes during LOAD or WAIT_ACK are not re-arbitrated. They are evaluated on the first PLAY cycle.
- If all keys release during LOAD or WAIT_ACK, the reload still completes, PLAY is entered for one cycle, and the FSM then returns to IDLE.
- FP_PERIOD_IN and ACTIVE_KEY change only when a winner is latched and hold otherwise.

## Timing
- Reset values: FP_PERIOD_IN=RESET_PERIOD (48), en=0, MUTE=1, ACTIVE_KEY=0, BUSY=0, all `deb`=0, state IDLE.
  - These values are applied asynchronously on RESET, including mid-reload. An en pulse in progress is truncated.
- en is registered, exactly one BIT_CLK wide, and always on the cycle immediately after a frame_sig cycle.
- en is never asserted twice without an intervening FP_PERIOD comparison.
- Key-to-en latency:
  - Raw KEYS edge to `deb` change: 2 sync cycles + DEBOUNCE_FRAMES frame_sig pulses + 1 cycle.
  - `deb` change to en: 1 cycle (IDLE/PLAY to LOAD) + wait for the next frame_sig + 1 cycle.
- BUSY is 1 exactly while the state is LOAD or WAIT_ACK.
- MUTE falls on the cycle after the WAIT_ACK match.
- frame_sig arriving on the same cycle the FSM enters LOAD is not used; LOAD waits for a frame_sig that occurs while already in LOAD.
- Simultaneous press of several keys: one arbitration, highest index wins, and a single reload is issued.

## Test plan
- Reset then idle: RESET pulse mid-sim with KEYS=0 → all outputs at reset values, no en for 200 frames.
- Single key: hold KEYS[0] → after 4 frames `deb[0]`=1; en one cycle after the next frame_sig; FP_PERIOD_IN=88; MUTE falls after the model echoes 88. Release → MUTE=1 after 4 frames, no further en.
- Preempt and ignore: in PLAY on key 2 (70), press key 5 → reload to 52, ACTIVE_KEY=5, MUTE stays 0. Then press key 1 → no en. Release key 5 → reload to 70, ACTIVE_KEY=2.
- Bounce rejection: toggle KEYS[3] every 2 frames for 20 frames → `deb[3]` never changes and no en is issued.
- Ack retry: the oscillator model ignores the first en → FSM returns to LOAD, issues a second en at the next frame, and MUTE falls only after the match.
- Async reset mid-reload: assert RESET on the en cycle → en=0 in the same cycle, FP_PERIOD_IN=48, state IDLE; a held key is re-debounced from scratch.
